// File: rtl/control_sequencer_pkg.sv
// Shared types, opcodes and IR field layout for the hardwired control sequencer.
package ctrl_pkg;

    localparam int unsigned IR_W            = 32;
    localparam int unsigned OPC_W           = 5;
    localparam int unsigned REG_IDX_W       = 4;
    localparam int unsigned NREG_DEF        = 16;
    localparam int unsigned OPW_DEF         = 5;
    localparam int unsigned MEM_TIMEOUT_DEF = 8;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RA_MSB  = 26;
    localparam int unsigned RA_LSB  = 23;
    localparam int unsigned RB_MSB  = 22;
    localparam int unsigned RB_LSB  = 19;
    localparam int unsigned RC_MSB  = 18;
    localparam int unsigned RC_LSB  = 15;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b01010;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b01011;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01100;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b01101;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11000;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11001;

    typedef enum logic [3:0] {
        S_RESET,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU2,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    // Single-bit datapath strobes, grouped so the FSM can default them in one assignment.
    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic zhigh_out;
        logic mdr_out;
        logic mar_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic lo_in;
        logic hi_in;
        logic inc_pc;
        logic read;
    } strobe_t;

    function automatic op_class_e op_class(input logic [OPC_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:          return CLS_ALU2;
            OP_NEG, OP_NOT:                         return CLS_UNARY;
            OP_MUL, OP_DIV:                         return CLS_MULDIV;
            OP_NOP:                                 return CLS_NOP;
            OP_HALT:                                return CLS_HALT;
            default:                                return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: IR/handshake in, strobes and register selects out.
interface control_sequencer_if
    import ctrl_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned OPW  = OPW_DEF
);
    logic [IR_W-1:0] ir;
    logic            mem_ready;
    logic            stop;

    logic            PCout;
    logic            ZLowout;
    logic            ZHighout;
    logic            MDRout;
    logic            MARin;
    logic            PCin;
    logic            MDRin;
    logic            IRin;
    logic            Yin;
    logic            Zin;
    logic            LOin;
    logic            HIin;
    logic            IncPC;
    logic            Read;
    logic [NREG-1:0] reg_out_sel;
    logic [NREG-1:0] reg_in_sel;
    logic [OPW-1:0]  alu_op;
    logic            run;
    logic            illegal_op;
    logic            mem_fault;

    modport master (
        input  ir, mem_ready, stop,
        output PCout, ZLowout, ZHighout, MDRout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin,
        output IncPC, Read, reg_out_sel, reg_in_sel, alu_op,
        output run, illegal_op, mem_fault
    );

    modport slave (
        output ir, mem_ready, stop,
        input  PCout, ZLowout, ZHighout, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin,
        input  IncPC, Read, reg_out_sel, reg_in_sel, alu_op,
        input  run, illegal_op, mem_fault
    );
endinterface

// File: rtl/control_sequencer_sel_decoder.sv
// Register-index to one-hot select decoder with an enable.
module sel_decoder
    import ctrl_pkg::*;
#(
    parameter int unsigned NREG  = NREG_DEF,
    parameter int unsigned IDX_W = REG_IDX_W
)(
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [NREG-1:0]  o_sel
);
    always_comb begin
        o_sel = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            o_sel[i] = i_en && (i_idx == IDX_W'(i));
        end
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit: Moore strobes decoded from the T-state and IR fields.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned NREG        = NREG_DEF,
    parameter int unsigned OPW         = OPW_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
)(
    input  logic                Clock,
    input  logic                Clear,
    control_sequencer_if.master bus
);
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             r_mem_fault;
    logic             w_mem_fault_nxt;
    logic             r_stop_pend;
    logic             w_stop_pend_nxt;

    strobe_t          w_strb;
    logic             w_out_en;
    logic [REG_IDX_W-1:0] w_out_idx;
    logic             w_in_en;
    logic [OPW-1:0]   w_alu_op;
    logic             w_illegal;
    state_e           w_boundary;

    logic [OPC_W-1:0]     w_opcode;
    logic [REG_IDX_W-1:0] w_ra;
    logic [REG_IDX_W-1:0] w_rb;
    logic [REG_IDX_W-1:0] w_rc;
    op_class_e            w_cls;
    logic                 w_unused_ir;

    assign w_opcode    = bus.ir[OPC_MSB:OPC_LSB];
    assign w_ra        = bus.ir[RA_MSB:RA_LSB];
    assign w_rb        = bus.ir[RB_MSB:RB_LSB];
    assign w_rc        = bus.ir[RC_MSB:RC_LSB];
    assign w_cls       = op_class(w_opcode);
    assign w_unused_ir = ^bus.ir[RC_LSB-1:0];

    // A stop seen at any point in the instruction wins at the next boundary.
    assign w_boundary = (r_stop_pend || bus.stop) ? S_HALT : S_T0;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_state     <= S_RESET;
            r_wait_cnt  <= '0;
            r_mem_fault <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_mem_fault <= w_mem_fault_nxt;
            r_stop_pend <= w_stop_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_mem_fault_nxt = r_mem_fault;
        w_stop_pend_nxt = r_stop_pend || bus.stop;
        w_strb          = '0;
        w_out_en        = 1'b0;
        w_out_idx       = '0;
        w_in_en         = 1'b0;
        w_alu_op        = '0;
        w_illegal       = 1'b0;

        case (r_state)
            S_RESET: begin
                w_state_nxt = S_T0;
            end
            S_T0: begin
                w_strb.pc_out = 1'b1;
                w_strb.mar_in = 1'b1;
                w_strb.inc_pc = 1'b1;
                w_strb.z_in   = 1'b1;
                w_state_nxt   = S_T1;
            end
            S_T1: begin
                w_strb.zlow_out = 1'b1;
                w_strb.read     = 1'b1;
                w_strb.mdr_in   = 1'b1;
                // PC only takes the increment once the read completes, so a stall is replay-safe.
                if (bus.mem_ready) begin
                    w_strb.pc_in   = 1'b1;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = S_T2;
                end else if (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                    w_wait_cnt_nxt  = '0;
                    w_mem_fault_nxt = 1'b1;
                    w_state_nxt     = S_HALT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            S_T2: begin
                w_strb.mdr_out = 1'b1;
                w_strb.ir_in   = 1'b1;
                w_state_nxt    = S_T3;
            end
            S_T3: begin
                case (w_cls)
                    CLS_ALU2: begin
                        w_out_en    = 1'b1;
                        w_out_idx   = w_rb;
                        w_strb.y_in = 1'b1;
                        w_state_nxt = S_T4;
                    end
                    CLS_UNARY: begin
                        w_out_en    = 1'b1;
                        w_out_idx   = w_rb;
                        w_strb.z_in = 1'b1;
                        w_alu_op    = OPW'(w_opcode);
                        w_state_nxt = S_T5;
                    end
                    CLS_MULDIV: begin
                        w_out_en    = 1'b1;
                        w_out_idx   = w_ra;
                        w_strb.y_in = 1'b1;
                        w_state_nxt = S_T4;
                    end
                    CLS_NOP: begin
                        w_state_nxt = w_boundary;
                    end
                    CLS_HALT: begin
                        w_state_nxt = S_HALT;
                    end
                    default: begin
                        w_illegal   = 1'b1;
                        w_state_nxt = w_boundary;
                    end
                endcase
            end
            S_T4: begin
                w_out_en    = 1'b1;
                w_out_idx   = (w_cls == CLS_MULDIV) ? w_rb : w_rc;
                w_strb.z_in = 1'b1;
                w_alu_op    = OPW'(w_opcode);
                w_state_nxt = S_T5;
            end
            S_T5: begin
                w_strb.zlow_out = 1'b1;
                if (w_cls == CLS_MULDIV) begin
                    w_strb.lo_in = 1'b1;
                    w_state_nxt  = S_T6;
                end else begin
                    w_in_en     = 1'b1;
                    w_state_nxt = w_boundary;
                end
            end
            S_T6: begin
                w_strb.zhigh_out = 1'b1;
                w_strb.hi_in     = 1'b1;
                w_state_nxt      = w_boundary;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_RESET;
            end
        endcase
    end

    sel_decoder #(.NREG(NREG), .IDX_W(REG_IDX_W)) u_out_sel (
        .i_idx (w_out_idx),
        .i_en  (w_out_en),
        .o_sel (bus.reg_out_sel)
    );

    sel_decoder #(.NREG(NREG), .IDX_W(REG_IDX_W)) u_in_sel (
        .i_idx (w_ra),
        .i_en  (w_in_en),
        .o_sel (bus.reg_in_sel)
    );

    assign bus.PCout      = w_strb.pc_out;
    assign bus.ZLowout    = w_strb.zlow_out;
    assign bus.ZHighout   = w_strb.zhigh_out;
    assign bus.MDRout     = w_strb.mdr_out;
    assign bus.MARin      = w_strb.mar_in;
    assign bus.PCin       = w_strb.pc_in;
    assign bus.MDRin      = w_strb.mdr_in;
    assign bus.IRin       = w_strb.ir_in;
    assign bus.Yin        = w_strb.y_in;
    assign bus.Zin        = w_strb.z_in;
    assign bus.LOin       = w_strb.lo_in;
    assign bus.HIin       = w_strb.hi_in;
    assign bus.IncPC      = w_strb.inc_pc;
    assign bus.Read       = w_strb.read;
    assign bus.alu_op     = w_alu_op;
    assign bus.illegal_op = w_illegal;
    assign bus.mem_fault  = r_mem_fault;
    assign bus.run        = (r_state != S_RESET) && (r_state != S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: directed per-cycle expectations queued by stimulus, checked by a negedge monitor.
module tb_control_sequencer;

    typedef struct packed {
        logic        pcout;
        logic        zlowout;
        logic        zhighout;
        logic        mdrout;
        logic        marin;
        logic        pcin;
        logic        mdrin;
        logic        irin;
        logic        yin;
        logic        zin;
        logic        loin;
        logic        hiin;
        logic        incpc;
        logic        read;
        logic [15:0] out_sel;
        logic [15:0] in_sel;
        logic [4:0]  alu;
        logic        run;
        logic        illegal;
        logic        fault;
    } obs_t;

    logic clk;
    logic clear;
    logic exp_fault;
    int   n_vec;
    int   n_err;
    obs_t exp_q[$];
    string tag_q[$];

    control_sequencer_if #(.NREG(16), .OPW(5)) bus ();

    control_sequencer #(.NREG(16), .OPW(5), .MEM_TIMEOUT(8)) dut (
        .Clock (clk),
        .Clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t idle(input logic run);
        obs_t o;
        o       = '0;
        o.run   = run;
        o.fault = exp_fault;
        return o;
    endfunction

    function automatic obs_t e_t0();
        obs_t o;
        o       = idle(1'b1);
        o.pcout = 1'b1;
        o.marin = 1'b1;
        o.incpc = 1'b1;
        o.zin   = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_t1(input logic rdy);
        obs_t o;
        o         = idle(1'b1);
        o.zlowout = 1'b1;
        o.read    = 1'b1;
        o.mdrin   = 1'b1;
        o.pcin    = rdy;
        return o;
    endfunction

    function automatic obs_t e_t2();
        obs_t o;
        o        = idle(1'b1);
        o.mdrout = 1'b1;
        o.irin   = 1'b1;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a.pcout    = bus.PCout;
        a.zlowout  = bus.ZLowout;
        a.zhighout = bus.ZHighout;
        a.mdrout   = bus.MDRout;
        a.marin    = bus.MARin;
        a.pcin     = bus.PCin;
        a.mdrin    = bus.MDRin;
        a.irin     = bus.IRin;
        a.yin      = bus.Yin;
        a.zin      = bus.Zin;
        a.loin     = bus.LOin;
        a.hiin     = bus.HIin;
        a.incpc    = bus.IncPC;
        a.read     = bus.Read;
        a.out_sel  = bus.reg_out_sel;
        a.in_sel   = bus.reg_in_sel;
        a.alu      = bus.alu_op;
        a.run      = bus.run;
        a.illegal  = bus.illegal_op;
        a.fault    = bus.mem_fault;
        return a;
    endfunction

    // Apply one cycle of inputs and queue what the outputs must be during that cycle.
    task automatic step(input logic rdy, input logic stp, input obs_t e, input string tag);
        bus.mem_ready = rdy;
        bus.stop      = stp;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag);
        step(1'b1, 1'b0, e_t0(),     {tag, "_t0"});
        step(1'b1, 1'b0, e_t1(1'b1), {tag, "_t1"});
        step(1'b1, 1'b0, e_t2(),     {tag, "_t2"});
    endtask

    always @(negedge clk) begin
        obs_t  a;
        obs_t  e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = sample();
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", t, a, e);
            end
        end
    end

    initial begin
        obs_t o;
        n_vec         = 0;
        n_err         = 0;
        exp_fault     = 1'b0;
        clear         = 1'b0;
        bus.ir        = '0;
        bus.mem_ready = 1'b1;
        bus.stop      = 1'b0;
        @(posedge clk);
        #1;

        step(1'b1, 1'b0, idle(1'b0), "rst0");
        step(1'b1, 1'b0, idle(1'b0), "rst1");
        clear = 1'b1;
        step(1'b1, 1'b0, idle(1'b0), "rst_rel");

        // shr R4 <- R5 >> R7
        bus.ir = 32'h2A2B8000;
        fetch("shr");
        o = idle(1'b1); o.out_sel = 16'h0020; o.yin = 1'b1;
        step(1'b1, 1'b0, o, "shr_t3");
        o = idle(1'b1); o.out_sel = 16'h0080; o.zin = 1'b1; o.alu = 5'b00101;
        step(1'b1, 1'b0, o, "shr_t4");
        o = idle(1'b1); o.zlowout = 1'b1; o.in_sel = 16'h0010;
        step(1'b1, 1'b0, o, "shr_t5");

        // nop with a 3-cycle memory stall
        bus.ir = 32'hC0000000;
        step(1'b1, 1'b0, e_t0(), "nop_t0");
        repeat (3) step(1'b0, 1'b0, e_t1(1'b0), "stall_t1");
        step(1'b1, 1'b0, e_t1(1'b1), "stall_t1_rdy");
        step(1'b1, 1'b0, e_t2(), "nop_t2");
        step(1'b1, 1'b0, idle(1'b1), "nop_t3");

        // mul Ra=2 Rb=3
        bus.ir = {5'b01100, 4'd2, 4'd3, 4'd0, 15'd0};
        fetch("mul");
        o = idle(1'b1); o.out_sel = 16'h0004; o.yin = 1'b1;
        step(1'b1, 1'b0, o, "mul_t3");
        o = idle(1'b1); o.out_sel = 16'h0008; o.zin = 1'b1; o.alu = 5'b01100;
        step(1'b1, 1'b0, o, "mul_t4");
        o = idle(1'b1); o.zlowout = 1'b1; o.loin = 1'b1;
        step(1'b1, 1'b0, o, "mul_t5");
        o = idle(1'b1); o.zhighout = 1'b1; o.hiin = 1'b1;
        step(1'b1, 1'b0, o, "mul_t6");

        // undefined opcode
        bus.ir = 32'hF8000000;
        fetch("ill");
        o = idle(1'b1); o.illegal = 1'b1;
        step(1'b1, 1'b0, o, "ill_t3");

        // add R1 <- R2 + R3 with stop during T3
        bus.ir = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
        fetch("add");
        o = idle(1'b1); o.out_sel = 16'h0004; o.yin = 1'b1;
        step(1'b1, 1'b1, o, "add_t3");
        o = idle(1'b1); o.out_sel = 16'h0008; o.zin = 1'b1; o.alu = 5'b00011;
        step(1'b1, 1'b0, o, "add_t4");
        o = idle(1'b1); o.zlowout = 1'b1; o.in_sel = 16'h0002;
        step(1'b1, 1'b0, o, "add_t5");
        repeat (3) step(1'b1, 1'b0, idle(1'b0), "stop_halt");

        clear = 1'b0;
        step(1'b1, 1'b0, idle(1'b0), "halt_clr0");
        step(1'b1, 1'b0, idle(1'b0), "halt_clr1");
        clear = 1'b1;
        step(1'b1, 1'b0, idle(1'b0), "halt_clr_rel");

        // halt opcode
        bus.ir = 32'hC8000000;
        fetch("hlt");
        step(1'b1, 1'b0, idle(1'b1), "hlt_t3");
        repeat (10) step(1'b1, 1'b0, idle(1'b0), "hlt_hold");

        clear = 1'b0;
        step(1'b1, 1'b0, idle(1'b0), "hlt_clr");
        clear = 1'b1;
        step(1'b1, 1'b0, idle(1'b0), "hlt_clr_rel");

        // Clear asserted while in T4
        bus.ir = 32'h2A2B8000;
        fetch("clr");
        o = idle(1'b1); o.out_sel = 16'h0020; o.yin = 1'b1;
        step(1'b1, 1'b0, o, "clr_t3");
        clear = 1'b0;
        step(1'b1, 1'b0, idle(1'b0), "clr_t4_0");
        step(1'b1, 1'b0, idle(1'b0), "clr_t4_1");
        clear = 1'b1;
        step(1'b1, 1'b0, idle(1'b0), "clr_rel");
        step(1'b1, 1'b0, e_t0(), "clr_after_t0");

        // memory timeout
        repeat (8) step(1'b0, 1'b0, e_t1(1'b0), "to_t1");
        exp_fault = 1'b1;
        repeat (3) step(1'b1, 1'b0, idle(1'b0), "to_halt");
        clear     = 1'b0;
        exp_fault = 1'b0;
        step(1'b1, 1'b0, idle(1'b0), "fault_clr");
        clear = 1'b1;
        step(1'b1, 1'b0, idle(1'b0), "fault_clr_rel");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
